// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcodes, controller states, decode classes and field
//            positions for the 12-bit multi-cycle CPU controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BEQZ  = 3'b100,
        OP_JMP   = 3'b101,
        OP_NOP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_IRLD   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_PAUSE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WR   = 2'd2
    } mem_cls_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_cls_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_Z    = 2'd1,
        BR_JMP  = 2'd2
    } br_cls_t;

    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 9;
    localparam int RD_MSB   = 8;
    localparam int RD_LSB   = 6;
    localparam int RA_MSB   = 5;
    localparam int RA_LSB   = 3;
    localparam int RB_MSB   = 2;
    localparam int RB_LSB   = 0;
    localparam int ADDR_MSB = 5;
    localparam int ADDR_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Combinational decode of the latched instruction into register
//            addresses, ALU select, memory/writeback class and branch type.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [11:0] instr,
    output logic [2:0]  ra,
    output logic [2:0]  rb,
    output logic [2:0]  wa,
    output logic        alu_op,
    output logic [1:0]  mem_cls,
    output logic [1:0]  wb_cls,
    output logic [1:0]  br_cls,
    output logic        is_halt,
    output logic [5:0]  addr
);

    opcode_t w_op;

    always_comb begin
        w_op    = opcode_t'(instr[OP_MSB:OP_LSB]);
        // M-type reads its register operand on port A (STORE data, BEQZ test)
        ra      = instr[RD_MSB:RD_LSB];
        rb      = '0;
        wa      = instr[RD_MSB:RD_LSB];
        alu_op  = 1'b0;
        mem_cls = MEM_NONE;
        wb_cls  = WB_NONE;
        br_cls  = BR_NONE;
        is_halt = 1'b0;
        addr    = instr[ADDR_MSB:ADDR_LSB];
        case (w_op)
            OP_LOAD: begin
                mem_cls = MEM_RD;
                wb_cls  = WB_MEM;
            end
            OP_STORE: mem_cls = MEM_WR;
            OP_ADD, OP_SUB: begin
                ra     = instr[RA_MSB:RA_LSB];
                rb     = instr[RB_MSB:RB_LSB];
                alu_op = (w_op == OP_SUB);
                wb_cls = WB_ALU;
            end
            OP_BEQZ: br_cls  = BR_Z;
            OP_JMP:  br_cls  = BR_JMP;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Four-cycle FETCH/IRLD/EXEC/WB sequencer driving PC, IR load,
//            register file, ALU and data memory. Optional single-step PAUSE
//            state enabled by defining CPU_CTRL_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int PC_W  = 6,
    parameter int RF_AW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CPU_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [11:0]      instr,
    input  logic             zero_flag,
    output logic [PC_W-1:0]  pc,
    output logic             imem_en,
    output logic             ir_load,
    output logic [RF_AW-1:0] rf_ra,
    output logic [RF_AW-1:0] rf_rb,
    output logic [RF_AW-1:0] rf_wa,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             alu_op,
    output logic [5:0]       dmem_addr,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             busy,
    output logic             halted
);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;

    logic [2:0] w_ra, w_rb, w_wa;
    logic       w_alu_op, w_is_halt;
    logic [1:0] w_mem_cls, w_wb_cls, w_br_cls;
    logic [5:0] w_addr;
    logic       w_dec_active;
    logic       w_taken;

    instr_decoder u_dec (
        .instr   (instr),
        .ra      (w_ra),
        .rb      (w_rb),
        .wa      (w_wa),
        .alu_op  (w_alu_op),
        .mem_cls (w_mem_cls),
        .wb_cls  (w_wb_cls),
        .br_cls  (w_br_cls),
        .is_halt (w_is_halt),
        .addr    (w_addr)
    );

`ifdef CPU_CTRL_STEP_EN
    logic r_step_d;
    logic w_step_rise;

    assign w_step_rise = step & ~r_step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_step_d <= 1'b0;
        else        r_step_d <= step;
    end
`endif

    assign w_taken = (w_br_cls == BR_JMP) || ((w_br_cls == BR_Z) && zero_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_WB)
                r_pc <= w_taken ? PC_W'(w_addr) : r_pc + PC_W'(1);
        end
    end

    assign pc = r_pc;

    always_comb begin
        w_next       = r_state;
        imem_en      = 1'b0;
        ir_load      = 1'b0;
        dmem_re      = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = 1'b0;
        w_dec_active = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_FETCH;
            ST_FETCH: begin
                imem_en = 1'b1;
                w_next  = ST_IRLD;
            end
            ST_IRLD: begin
                ir_load = 1'b1;
                w_next  = ST_EXEC;
            end
            ST_EXEC: begin
                w_dec_active = 1'b1;
                dmem_re      = (w_mem_cls == MEM_RD);
                dmem_we      = (w_mem_cls == MEM_WR);
                w_next       = ST_WB;
            end
            ST_WB: begin
                w_dec_active = 1'b1;
                rf_we        = (w_wb_cls != WB_NONE);
                rf_wsel      = (w_wb_cls == WB_MEM);
`ifdef CPU_CTRL_STEP_EN
                w_next       = w_is_halt ? ST_HALTED : ST_PAUSE;
`else
                w_next       = w_is_halt ? ST_HALTED : ST_FETCH;
`endif
            end
            ST_HALTED: w_next = ST_HALTED;
`ifdef CPU_CTRL_STEP_EN
            ST_PAUSE: if (w_step_rise) w_next = ST_FETCH;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // Decode fields are held only while the IR contents are meaningful
    always_comb begin
        rf_ra     = w_dec_active ? RF_AW'(w_ra) : '0;
        rf_rb     = w_dec_active ? RF_AW'(w_rb) : '0;
        rf_wa     = w_dec_active ? RF_AW'(w_wa) : '0;
        alu_op    = w_dec_active & w_alu_op;
        dmem_addr = (w_dec_active && (w_mem_cls != MEM_NONE)) ? w_addr : '0;
    end

    assign busy   = (r_state == ST_FETCH) || (r_state == ST_IRLD) ||
                    (r_state == ST_EXEC)  || (r_state == ST_WB);
    assign halted = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Directed self-checking bench for cpu_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] instr;
    logic        zero_flag;
    logic [5:0]  pc;
    logic        imem_en, ir_load;
    logic [2:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we, rf_wsel, alu_op;
    logic [5:0]  dmem_addr;
    logic        dmem_re, dmem_we;
    logic        busy, halted;
`ifdef CPU_CTRL_STEP_EN
    logic        step;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_controller #(.PC_W(6), .RF_AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CPU_CTRL_STEP_EN
        .step      (step),
`endif
        .start     (start),
        .instr     (instr),
        .zero_flag (zero_flag),
        .pc        (pc),
        .imem_en   (imem_en),
        .ir_load   (ir_load),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_wa     (rf_wa),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .alu_op    (alu_op),
        .dmem_addr (dmem_addr),
        .dmem_re   (dmem_re),
        .dmem_we   (dmem_we),
        .busy      (busy),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called while sampling in FETCH: present the instruction, pass IRLD, land in EXEC
    task automatic to_exec(input logic [11:0] ins);
        instr = ins;
        tick();
        check("irld_ir_load", {31'd0, ir_load}, 32'd1);
        tick();
    endtask

    // Called while sampling in WB: move on to the next FETCH
    task automatic finish_wb();
        tick();
`ifdef CPU_CTRL_STEP_EN
        check("pause_busy", {31'd0, busy}, 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr = 12'h000; zero_flag = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_pc",      {26'd0, pc}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_halted",  {31'd0, halted}, 32'd0);
        check("rst_strobes", {28'd0, imem_en, ir_load, dmem_re, dmem_we}, 32'd0);
        check("rst_rf_we",   {31'd0, rf_we}, 32'd0);
        check("rst_addr",    {17'd0, rf_ra, rf_rb, rf_wa, dmem_addr}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_wait", {30'd0, busy, imem_en}, 32'd0);

        // ADD r1,r2,r3
        start = 1'b1;
        tick();
        check("fetch_imem_en", {31'd0, imem_en}, 32'd1);
        check("fetch_busy",    {31'd0, busy}, 32'd1);
        start = 1'b0;
        to_exec(12'h453);
        check("add_exec_ra", {29'd0, rf_ra}, 32'd2);
        check("add_exec_rb", {29'd0, rf_rb}, 32'd3);
        check("add_exec_we", {31'd0, rf_we}, 32'd0);
        tick();
        check("add_wb_we",   {31'd0, rf_we}, 32'd1);
        check("add_wb_wa",   {29'd0, rf_wa}, 32'd1);
        check("add_wb_wsel", {31'd0, rf_wsel}, 32'd0);
        check("add_wb_alu",  {31'd0, alu_op}, 32'd0);
        check("add_wb_pc",   {26'd0, pc}, 32'd0);
        finish_wb();
        check("add_pc",      {26'd0, pc}, 32'd1);
        check("add_refetch", {31'd0, imem_en}, 32'd1);

        // SUB r4,r5,r6
        to_exec(12'h72E);
        check("sub_exec_alu", {31'd0, alu_op}, 32'd1);
        tick();
        check("sub_wb_alu", {31'd0, alu_op}, 32'd1);
        check("sub_wb_wa",  {29'd0, rf_wa}, 32'd4);
        finish_wb();
        check("sub_pc", {26'd0, pc}, 32'd2);

        // LOAD r2,[5]
        to_exec(12'h085);
        check("ld_exec_re",   {31'd0, dmem_re}, 32'd1);
        check("ld_exec_addr", {26'd0, dmem_addr}, 32'd5);
        check("ld_exec_we",   {30'd0, dmem_we, rf_we}, 32'd0);
        tick();
        check("ld_wb_we",   {31'd0, rf_we}, 32'd1);
        check("ld_wb_wsel", {31'd0, rf_wsel}, 32'd1);
        check("ld_wb_wa",   {29'd0, rf_wa}, 32'd2);
        check("ld_wb_re",   {31'd0, dmem_re}, 32'd0);
        check("ld_wb_addr", {26'd0, dmem_addr}, 32'd5);
        finish_wb();
        check("ld_pc", {26'd0, pc}, 32'd3);

        // STORE r7,[9]
        to_exec(12'h3C9);
        check("st_exec_we",   {31'd0, dmem_we}, 32'd1);
        check("st_exec_ra",   {29'd0, rf_ra}, 32'd7);
        check("st_exec_addr", {26'd0, dmem_addr}, 32'd9);
        tick();
        check("st_wb_quiet", {30'd0, dmem_we, rf_we}, 32'd0);
        finish_wb();
        check("st_pc", {26'd0, pc}, 32'd4);

        // BEQZ r0,[20] not taken, then taken
        to_exec(12'h814);
        check("bz_exec_ra", {29'd0, rf_ra}, 32'd0);
        tick();
        finish_wb();
        check("bz_nt_pc", {26'd0, pc}, 32'd5);
        to_exec(12'h814);
        zero_flag = 1'b1;
        tick();
        finish_wb();
        zero_flag = 1'b0;
        check("bz_t_pc", {26'd0, pc}, 32'd20);

        // JMP [63], then NOP at 63 wraps to 0
        to_exec(12'hA3F);
        tick();
        finish_wb();
        check("jmp_pc", {26'd0, pc}, 32'd63);
        to_exec(12'hC00);
        tick();
        check("nop_wb_we", {31'd0, rf_we}, 32'd0);
        finish_wb();
        check("wrap_pc", {26'd0, pc}, 32'd0);

        // ADD to move pc off zero, then abort a STORE mid-EXEC
        to_exec(12'h453);
        tick();
        finish_wb();
        check("pre_abort_pc", {26'd0, pc}, 32'd1);
        instr = 12'h3C9;
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("abort_pc",      {26'd0, pc}, 32'd0);
        check("abort_busy",    {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_idle", {28'd0, busy, imem_en, dmem_we, halted}, 32'd0);
        check("abort_pc2",  {26'd0, pc}, 32'd0);

        // HALT is absorbing until reset
        start = 1'b1;
        tick();
        start = 1'b0;
        to_exec(12'hE00);
        tick();
        check("halt_wb_we", {31'd0, rf_we}, 32'd0);
        tick();
        check("halted",      {31'd0, halted}, 32'd1);
        check("halted_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        tick();
        check("halt_hold",      {31'd0, halted}, 32'd1);
        check("halt_no_fetch",  {31'd0, imem_en}, 32'd0);
        check("halt_pc",        {26'd0, pc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("halt_rst",    {31'd0, halted}, 32'd0);
        check("halt_rst_pc", {26'd0, pc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef CPU_CTRL_STEP_EN
        // Two NOPs with the controller parking in PAUSE after each
        start = 1'b1;
        tick();
        start = 1'b0;
        to_exec(12'hC00);
        tick();
        tick();
        repeat (3) tick();
        check("step_park_busy", {31'd0, busy}, 32'd0);
        check("step_park_imem", {31'd0, imem_en}, 32'd0);
        check("step_park_pc",   {26'd0, pc}, 32'd1);
        step = 1'b1;
        tick();
        check("step_fetch", {31'd0, imem_en}, 32'd1);
        to_exec(12'hC00);
        tick();
        tick();
        tick();
        check("step_level_no_adv", {31'd0, imem_en | busy}, 32'd0);
        check("step_pc2",          {26'd0, pc}, 32'd2);
        step = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle sequencer for the 12-bit accumulator-less CPU datapath. Drives the program counter and instruction-memory read, strobes the instruction register, then decodes the latched instruction to steer the register file, ALU and data memory. One instruction completes every 4 cycles: FETCH, IRLD, EXEC, WB. Sits between instruction memory/instruction register and the execute datapath.

## Interface
- PC_W, 6, program counter and branch-target width; must equal instruction address field width (6)
- RF_AW, 3, register-file address width (8 registers)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; leaves IDLE when high
- instr  in  12  instruction register output
- zero_flag  in  1  high when RF read port A data == 0
- pc  out  PC_W  instruction memory address
- imem_en  out  1  instruction memory read enable
- ir_load  out  1  instruction register load enable
- rf_ra, rf_rb  out  RF_AW  register-file read addresses
- rf_wa  out  RF_AW  register-file write address
- rf_we  out  1  register-file write enable
- rf_wsel  out  1  write data select: 0 ALU, 1 data memory
- alu_op  out  1  0 add, 1 subtract
- dmem_addr  out  6  data memory address
- dmem_re, dmem_we  out  1  data memory read/write strobes
- busy, halted  out  1  status

## Operation
- Format: op[11:9]; R-type rd[8:6] ra[5:3] rb[2:0]; M-type reg[8:6] addr[5:0].
- Opcodes: 000 LOAD RF[reg]<=DMEM[addr]; 001 STORE DMEM[addr]<=RF[reg]; 010 ADD rd<=ra+rb; 011 SUB rd<=ra-rb; 100 BEQZ if RF[reg]==0 pc<=addr; 101 JMP pc<=addr; 110 NOP; 111 HALT.
- States: IDLE, FETCH, IRLD, EXEC, WB, HALTED (plus PAUSE, see Configuration).
- IDLE: start=1 -> FETCH, else stay. FETCH: imem_en=1 -> IRLD. IRLD: ir_load=1 -> EXEC. EXEC -> WB. WB -> FETCH, except HALT -> HALTED.
- EXEC: rf_ra/rf_rb decoded (M-type: rf_ra=reg). LOAD asserts dmem_re. STORE asserts dmem_we. dmem_addr=addr for M-type.
- WB: ADD/SUB assert rf_we, rf_wa=rd, rf_wsel=0. LOAD asserts rf_we, rf_wa=reg, rf_wsel=1. BEQZ samples zero_flag.
- PC updates only at end of WB: taken BEQZ or JMP load addr, otherwise pc+1 modulo 2^PC_W (63 wraps to 0).
- HALTED: absorbing; only rst_n exits. halted=1.
- busy=1 in every state except IDLE and HALTED.
- Decode fields, ALU select and memory address stay stable throughout EXEC and WB. All strobes are single-cycle and decoded from the registered state.

## Timing
- Reset (asynchronous, immediate): state IDLE, pc=0. All strobes, rf_we, busy and halted are 0. Address outputs are 0.
- Instruction memory has a synchronous read with 1-cycle latency. Data presented during IRLD is captured into the IR at the end of IRLD. instr is valid from EXEC onward.
- Data memory has a 1-cycle read latency: the EXEC read produces data in WB.
- Instruction period is 4 cycles. From start to the first imem_en is 1 cycle.
- start deasserting mid-program has no effect; start is sampled only in IDLE.
- rst_n asserted in any state aborts the current instruction. A pending WB write or PC update is discarded.

## Configuration
- CPU_CTRL_STEP_EN defined: adds input step (1 bit) and state PAUSE. WB goes to PAUSE instead of FETCH. PAUSE waits for a step rising edge (internally registered detect), then goes to FETCH. busy=0 in PAUSE. HALT still goes to HALTED.
- Undefined: no step port and no PAUSE state; WB goes directly to FETCH.

## Structure
- Package cpu_pkg holds:
  - opcode enum;
  - controller state enum;
  - field bit-position constants (OP_MSB=11, OP_LSB=9, etc.).
- Sub-module instr_decoder: combinational. Takes instr and produces rf addresses, alu_op, memory/writeback class and branch type. The controller FSM instantiates it.

## Test plan
- Reset then start=1, instr=ADD r1,r2,r3 (12'h453) -> imem_en at cycle 1, ir_load at cycle 2, WB at cycle 4 with rf_we=1, rf_wa=1, rf_wsel=0, alu_op=0; pc 0->1.
- LOAD r2,[5] (12'h085) -> dmem_re with dmem_addr=5 in EXEC; rf_we=1, rf_wsel=1, rf_wa=2 in WB.
- BEQZ r0,[20] (12'h814): with zero_flag=1, pc becomes 20 after WB; with zero_flag=0, pc becomes pc+1. JMP with pc=63 and NOP at pc=63 -> pc wraps to 0.
- HALT (12'hE00) -> halted=1, busy=0; later start pulses are ignored until rst_n is asserted.
- rst_n low during EXEC of STORE -> dmem_we never asserts, and pc=0 and state=IDLE immediately.
- With CPU_CTRL_STEP_EN defined, two NOPs -> controller stops in PAUSE after each; one step pulse advances exactly one instruction.
